// File: rtl/run_monitor_pkg.sv
// Shared encodings and snapshot-word layout helpers for the run supervisor.
package run_monitor_pkg;

    // Supervisor state encoding, as seen on the state output.
    localparam logic [1:0] RM_RUN     = 2'd0;
    localparam logic [1:0] RM_HALTED  = 2'd1;
    localparam logic [1:0] RM_TIMEOUT = 2'd2;

    // Snapshot word layout: {watch registers, cycle stamp}, stamp in the low bits.
    function automatic int unsigned rm_snap_width(input int unsigned nregs,
                                                  input int unsigned width,
                                                  input int unsigned cnt_w);
        return nregs * width + cnt_w;
    endfunction

    function automatic int unsigned rm_cycle_lsb();
        return 0;
    endfunction

    function automatic int unsigned rm_data_lsb(input int unsigned cnt_w);
        return cnt_w;
    endfunction

endpackage

// File: rtl/snapshot_fifo.sv
// First-word-fall-through snapshot FIFO: register array, pointers one bit wider than the index.
module snapshot_fifo #(
    parameter int unsigned WIDTH = 112,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         dout
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             do_push, do_pop;

    // Status flags and head word; a pop frees a slot for a same-cycle push when full.
    always_comb begin
        empty   = (wptr_q == rptr_q);
        full    = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
        count   = wptr_q - rptr_q;
        dout    = mem_q[rptr_q[AW-1:0]];
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = do_pop ? rptr_q + 1'b1 : rptr_q;
    end

    // Pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage array; reset discards stale snapshots.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/run_monitor.sv
// Run supervisor: cycle counter, halt detect, cycle-budget watchdog and timestamped snapshots.
module run_monitor #(
    parameter int unsigned NREGS   = 3,
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 800
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     halt,
    input  logic                     dump,
    input  logic [NREGS*WIDTH-1:0]   watch,
    input  logic                     rd_en,
    output logic [1:0]               state,
    output logic                     done,
    output logic [CNT_W-1:0]         cycles,
    output logic                     snap_valid,
    output logic [NREGS*WIDTH-1:0]   snap_data,
    output logic [CNT_W-1:0]         snap_cycle,
    output logic [$clog2(DEPTH):0]   snap_count,
    output logic                     snap_ovf
);

    import run_monitor_pkg::*;

    localparam int unsigned DW       = NREGS * WIDTH;
    localparam int unsigned SW       = rm_snap_width(NREGS, WIDTH, CNT_W);
    localparam int unsigned CYC_LSB  = rm_cycle_lsb();
    localparam int unsigned DATA_LSB = rm_data_lsb(CNT_W);
    localparam int unsigned CNT_BITS = $clog2(DEPTH) + 1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]          state_q, state_d;
    logic [CNT_W-1:0]    cycles_q, cycles_d;
    logic                halt_q, dump_q;
    logic                ovf_q, ovf_d;
    logic                halt_ev, dump_ev, running, push;
    logic                fifo_full, fifo_empty;
    logic [SW-1:0]       fifo_din, fifo_dout;
    logic [CNT_BITS-1:0] fifo_count;

    // Rising-edge detection; the registered copies reset low so a held level counts once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halt_q <= 1'b0;
            dump_q <= 1'b0;
        end else begin
            halt_q <= halt;
            dump_q <= dump;
        end
    end

    assign halt_ev = halt & ~halt_q;
    assign dump_ev = dump & ~dump_q;
    assign running = (state_q == RM_RUN);

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RM_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: halt wins over timeout; terminal states only leave through reset.
    always_comb begin
        state_d = state_q;
        if (running) begin
            if (halt_ev) begin
                state_d = RM_HALTED;
            end else if ((TIMEOUT != 0) && (cycles_q == TO_LAST)) begin
                state_d = RM_TIMEOUT;
            end
        end
    end

    // FSM outputs.
    always_comb begin
        state = state_q;
        done  = ~running;
    end

    // Cycle counter next state: counts every RUN cycle, saturating.
    always_comb begin
        cycles_d = cycles_q;
        if (running && (cycles_q != CNT_MAX)) begin
            cycles_d = cycles_q + 1'b1;
        end
    end

    // Counter and sticky overflow registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycles_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            cycles_q <= cycles_d;
            ovf_q    <= ovf_d;
        end
    end

    // Capture request and overflow: a push is lost only when full with no pop freeing a slot.
    always_comb begin
        push     = dump_ev & running;
        fifo_din = {watch, cycles_q};
        ovf_d    = ovf_q | (push & fifo_full & ~(rd_en & ~fifo_empty));
    end

    snapshot_fifo #(
        .WIDTH (SW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (rd_en),
        .din   (fifo_din),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count),
        .dout  (fifo_dout)
    );

    // Output split; the head fields read zero while the FIFO is empty.
    always_comb begin
        cycles     = cycles_q;
        snap_valid = ~fifo_empty;
        snap_count = fifo_count;
        snap_ovf   = ovf_q;
        snap_data  = fifo_empty ? '0 : fifo_dout[DATA_LSB +: DW];
        snap_cycle = fifo_empty ? '0 : fifo_dout[CYC_LSB +: CNT_W];
    end

endmodule

// File: doc/run_monitor.md
# run_monitor

Synthesizable run supervisor for the single-cycle CPU, replacing ad-hoc bench-only timeout, halt and dump-state logic with one parametrised block. Counts cycles from reset and detects the CPU halt strobe. Enforces a cycle-budget watchdog. Captures timestamped snapshots of N watched registers on each dump strobe into a drainable FIFO. Sits beside `scpu`, usable both in benches and on hardware behind a debug port.

## Interface
- `NREGS`, 3, number of watched register channels
- `WIDTH`, 32, bits per watched register
- `DEPTH`, 8, snapshot FIFO entries (power of two, ≥2)
- `CNT_W`, 16, cycle counter width
- `TIMEOUT`, 800, cycle budget; 0 disables the watchdog
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `halt`  in  1  CPU halt level
- `dump`  in  1  CPU dump-state level
- `watch`  in  NREGS*WIDTH  watched registers, channel k at [k*WIDTH +: WIDTH]
- `rd_en`  in  1  pop FIFO head
- `state`  out  2  RUN=0, HALTED=1, TIMEOUT=2; reset value RUN
- `done`  out  1  state != RUN; reset 0
- `cycles`  out  CNT_W  cycles spent in RUN, saturating; reset 0
- `snap_valid`  out  1  FIFO non-empty; reset 0
- `snap_data`  out  NREGS*WIDTH  head snapshot registers; reset 0
- `snap_cycle`  out  CNT_W  head snapshot timestamp; reset 0
- `snap_count`  out  $clog2(DEPTH)+1  occupancy; reset 0
- `snap_ovf`  out  1  sticky, a snapshot was dropped; reset 0

## Operation
- Edge detect: `halt_q`, `dump_q` registered copies, reset 0. Halt event = `halt & ~halt_q`. Dump event = `dump & ~dump_q`. A level held high across reset release counts as an edge on the first clock.
- FSM:
  - RUN → HALTED on a halt event.
  - RUN → TIMEOUT when `TIMEOUT`≠0 and `cycles` == TIMEOUT-1 with no halt event that cycle.
  - Halt beats timeout when both occur in the same cycle.
  - HALTED and TIMEOUT are terminal; only `reset` exits them.
- Counter: `cycles` increments every RUN cycle, including the transition cycle. It saturates at 2^CNT_W−1 and freezes outside RUN.
- Capture: a dump event in RUN pushes {`watch`, `cycles`}. The timestamp is the pre-increment `cycles` value of that cycle.
  - A dump in the same cycle as the halt event is still captured.
  - Dumps in terminal states are ignored.
- FIFO is first-word-fall-through.
  - Push when full and no pop that cycle: entry dropped, `snap_ovf` set.
  - Push and pop together when full: both succeed, count unchanged.
  - Pop when empty: ignored, no underflow.
  - Draining is allowed in any state.
- `snap_ovf` is cleared only by reset.

## Timing
- Halt event sampled on edge N: `state`/`done` change after edge N (1-cycle latency from `halt` rising).
- Timeout: `state`=TIMEOUT after the edge where `cycles` goes TIMEOUT-1 → TIMEOUT. At that point `cycles` reads TIMEOUT and then freezes.
- Dump event sampled on edge N: `snap_valid`/`snap_data`/`snap_count` updated after edge N.
- Pop on edge N: the next head, or `snap_valid`=0, is visible after edge N.
- Reset asserted mid-operation: every output returns to its reset value immediately (asynchronous). FIFO contents are discarded.

## Structure
- Package `run_monitor_pkg`:
  - state encoding localparams `RM_RUN`, `RM_HALTED`, `RM_TIMEOUT`
  - snapshot field-offset helpers
- Sub-module `snapshot_fifo`:
  - parameters WIDTH (=NREGS*WIDTH+CNT_W) and DEPTH
  - ports push/pop/full/empty/count/dout, async reset
  - implemented as a register array, pointers one bit wider than the index
- Top level holds the edge detectors, FSM, counter, overflow flag and output split.

## Test plan
- Halt at cycle 20 (`halt` rises after 20 edges) → `state`=HALTED one edge later, `cycles`=21 frozen, `done`=1.
- TIMEOUT=50, no halt → `state`=TIMEOUT after edge 50, `cycles`=50. With halt rising on that same edge → HALTED instead.
- Three dump pulses at cycles 5, 9, 9+ (held high 4 cycles counts once), `watch`={3,0x41,0xDEAD} → FIFO holds 2 entries stamped 5 and 9. Popping yields them in order, then `snap_valid`=0.
- DEPTH=8: ten dump events without pops → `snap_count`=8, `snap_ovf`=1, entries 1–8 kept. Push+pop on full → count stays 8, oldest removed.
- Reset asserted between edges with 4 entries queued and `state`=HALTED → all outputs zero/RUN immediately, not waiting for a clock. After release, counting restarts from 0.
- Pop with FIFO empty → no change, `snap_count`=0, no spurious `snap_valid`.
